// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch front-end: owns the PC, assembles 1/2-byte instructions
// from the combinational program ROM and queues them for decode. Define PREFETCH_EN for a 2-entry queue.
module instr_fetch_sequencer #(
   parameter logic [7:0] RESET_PC = 8'd0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       run,
   output logic [7:0] prog_addr,
   input  logic [7:0] prog_data,
   input  logic       redirect_valid,
   input  logic [7:0] redirect_pc,
   output logic       instr_valid,
   input  logic       instr_ready,
   output logic [7:0] instr_opcode,
   output logic [7:0] instr_operand,
   output logic       instr_len2,
   output logic [7:0] instr_pc
);

`ifdef PREFETCH_EN
   localparam logic [1:0] DEPTH = 2'd2;
`else
   localparam logic [1:0] DEPTH = 2'd1;
`endif

   typedef enum logic {FETCH_OP, FETCH_IMM} state_t;

   typedef struct packed {
      logic [7:0] opcode;
      logic [7:0] operand;
      logic       len2;
      logic [7:0] pc;
   } entry_t;

   function automatic logic is_two_byte(input logic [5:0] op6);
      case (op6)
         6'b100000, 6'b100001, 6'b100011,
         6'b101010, 6'b101100, 6'b101101: return 1'b1;
         default:                         return 1'b0;
      endcase
   endfunction

   state_t     state_p0, state_d;
   logic [7:0] pc_p0, pc_d;
   logic [7:0] opcode_p0, ipc_p0;
   logic       latch_op, push, pop, space, advance, vld_p1;
   entry_t     push_entry;
   entry_t     buf_p1 [2];
   logic [1:0] count_p1, cnt_after_pop;

   assign prog_addr     = pc_p0;
   assign vld_p1        = (count_p1 != 2'd0);
   assign instr_valid   = vld_p1;
   assign instr_opcode  = buf_p1[0].opcode;
   assign instr_operand = buf_p1[0].operand;
   assign instr_len2    = buf_p1[0].len2;
   assign instr_pc      = buf_p1[0].pc;

   // space is judged on the pre-pop occupancy, so a pop never frees a slot in the same cycle
   assign space         = (count_p1 < DEPTH);
   assign advance       = run && !redirect_valid;
   assign pop           = vld_p1 && instr_ready;
   assign cnt_after_pop = count_p1 - {1'b0, pop};

   always_comb begin
      state_d    = state_p0;
      pc_d       = pc_p0;
      latch_op   = 1'b0;
      push       = 1'b0;
      push_entry = '0;
      if (advance) begin
         case (state_p0)
            FETCH_OP: begin
               if (space) begin
                  latch_op = 1'b1;
                  pc_d     = pc_p0 + 8'd1;
                  if (is_two_byte(prog_data[7:2])) begin
                     state_d = FETCH_IMM;
                  end else begin
                     push       = 1'b1;
                     push_entry = '{prog_data, 8'd0, 1'b0, pc_p0};
                  end
               end
            end
            FETCH_IMM: begin
               push       = 1'b1;
               push_entry = '{opcode_p0, prog_data, 1'b1, ipc_p0};
               pc_d       = pc_p0 + 8'd1;
               state_d    = FETCH_OP;
            end
            default: state_d = FETCH_OP;
         endcase
      end
      if (redirect_valid) begin
         pc_d    = redirect_pc;
         state_d = FETCH_OP;
      end
   end

   // fetch stage registers and decode queue
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_p0  <= FETCH_OP;
         pc_p0     <= RESET_PC;
         count_p1  <= 2'd0;
         buf_p1[0] <= '0;
      end else begin
         state_p0 <= state_d;
         pc_p0    <= pc_d;
         if (latch_op) begin
            opcode_p0 <= prog_data;
            ipc_p0    <= pc_p0;
         end
         if (redirect_valid) begin
            count_p1 <= 2'd0;
         end else begin
            if (pop) buf_p1[0] <= buf_p1[1];
            if (push) begin
               if (cnt_after_pop == 2'd0) buf_p1[0] <= push_entry;
               else                       buf_p1[1] <= push_entry;
            end
            count_p1 <= cnt_after_pop + {1'b0, push};
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Directed bench for instr_fetch_sequencer; expectations follow PREFETCH_EN when defined.
module tb_instr_fetch_sequencer;

   logic       clk = 1'b0;
   logic       reset, run, redirect_valid, instr_ready;
   logic [7:0] redirect_pc;

   logic [7:0] rom_a [256];
   logic [7:0] rom_b [256];

   logic [7:0] a_prog_addr, a_prog_data, a_opcode, a_operand, a_pc;
   logic       a_valid, a_len2;
   logic [7:0] b_prog_addr, b_prog_data, b_opcode, b_operand, b_pc;
   logic       b_valid, b_len2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   assign a_prog_data = rom_a[a_prog_addr];
   assign b_prog_data = rom_b[b_prog_addr];

   instr_fetch_sequencer u_dut (
      .clk(clk), .reset(reset), .run(run),
      .prog_addr(a_prog_addr), .prog_data(a_prog_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(a_valid), .instr_ready(instr_ready),
      .instr_opcode(a_opcode), .instr_operand(a_operand),
      .instr_len2(a_len2), .instr_pc(a_pc)
   );

   instr_fetch_sequencer #(.RESET_PC(8'd255)) u_dut_hi (
      .clk(clk), .reset(reset), .run(run),
      .prog_addr(b_prog_addr), .prog_data(b_prog_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .instr_valid(b_valid), .instr_ready(instr_ready),
      .instr_opcode(b_opcode), .instr_operand(b_operand),
      .instr_len2(b_len2), .instr_pc(b_pc)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_roms();
      for (int i = 0; i < 256; i++) begin
         rom_a[i] = 8'h00;
         rom_b[i] = 8'h00;
      end
   endtask

   task automatic do_reset();
      reset          = 1'b0;
      redirect_valid = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic expect_a(input string tag, input logic [7:0] op, input logic [7:0] opd,
                           input logic len2, input logic [7:0] pc);
      chk({tag, ".valid"}, 32'(a_valid), 32'd1);
      chk({tag, ".op"},    32'(a_opcode), 32'(op));
      chk({tag, ".opd"},   32'(a_operand), 32'(opd));
      chk({tag, ".len2"},  32'(a_len2), 32'(len2));
      chk({tag, ".pc"},    32'(a_pc), 32'(pc));
   endtask

   initial begin
      reset = 1'b0; run = 1'b1; redirect_valid = 1'b0; redirect_pc = 8'h00; instr_ready = 1'b1;
      clear_roms();

      // Reset state and 2-byte then 1-byte sequence
      rom_a[0] = 8'h80; rom_a[1] = 8'h00; rom_a[2] = 8'h06;
      do_reset();
      chk("rst.valid", 32'(a_valid), 32'd0);
      chk("rst.fields", {a_opcode, a_operand, a_pc, 7'd0, a_len2}, 32'd0);
      chk("rst.addr", 32'(a_prog_addr), 32'd0);
      chk("rst.addr_hi", 32'(b_prog_addr), 32'd255);
      tick();
      chk("seq.addr1", 32'(a_prog_addr), 32'd1);
      chk("seq.nv1", 32'(a_valid), 32'd0);
      tick();
      expect_a("seq.e0", 8'h80, 8'h00, 1'b1, 8'd0);
      chk("seq.addr2", 32'(a_prog_addr), 32'd2);
      tick();
`ifndef PREFETCH_EN
      chk("seq.gap", 32'(a_valid), 32'd0);
      chk("seq.addr2b", 32'(a_prog_addr), 32'd2);
      tick();
`endif
      expect_a("seq.e1", 8'h06, 8'h00, 1'b0, 8'd2);
      chk("seq.addr3", 32'(a_prog_addr), 32'd3);

      // Back-pressure
      clear_roms();
      rom_a[0] = 8'h9D; rom_a[1] = 8'h06; rom_a[2] = 8'h05;
      instr_ready = 1'b0;
      do_reset();
      tick();
      expect_a("bp.e0", 8'h9D, 8'h00, 1'b0, 8'd0);
      for (int i = 1; i < 5; i++) begin
         tick();
         chk("bp.valid", 32'(a_valid), 32'd1);
         chk("bp.op", 32'(a_opcode), 32'h9D);
         chk("bp.pc", 32'(a_pc), 32'd0);
      end
`ifdef PREFETCH_EN
      chk("bp.addr", 32'(a_prog_addr), 32'd2);
`else
      chk("bp.addr", 32'(a_prog_addr), 32'd1);
`endif
      instr_ready = 1'b1;
      tick();
`ifdef PREFETCH_EN
      expect_a("bp.e1", 8'h06, 8'h00, 1'b0, 8'd1);
`else
      chk("bp.drain", 32'(a_valid), 32'd0);
`endif

      // Redirect during operand fetch
      clear_roms();
      rom_a[22] = 8'hA8; rom_a[23] = 8'h11; rom_a[8'h25] = 8'h04;
      do_reset();
      redirect_valid = 1'b1; redirect_pc = 8'd22;
      tick();
      redirect_valid = 1'b0;
      chk("rd.addr22", 32'(a_prog_addr), 32'd22);
      tick();
      chk("rd.addr23", 32'(a_prog_addr), 32'd23);
      chk("rd.nv0", 32'(a_valid), 32'd0);
      redirect_valid = 1'b1; redirect_pc = 8'h25;
      tick();
      redirect_valid = 1'b0;
      chk("rd.nv1", 32'(a_valid), 32'd0);
      chk("rd.addr25", 32'(a_prog_addr), 32'h25);
      tick();
      expect_a("rd.e0", 8'h04, 8'h00, 1'b0, 8'h25);
      chk("rd.addr26", 32'(a_prog_addr), 32'h26);

      // PC wrap with RESET_PC=255 (CMP opcode)
      clear_roms();
      rom_b[255] = 8'h8C; rom_b[0] = 8'hFE;
      do_reset();
      chk("wr.addr255", 32'(b_prog_addr), 32'd255);
      tick();
      chk("wr.addr0", 32'(b_prog_addr), 32'd0);
      chk("wr.nv", 32'(b_valid), 32'd0);
      tick();
      chk("wr.valid", 32'(b_valid), 32'd1);
      chk("wr.op", 32'(b_opcode), 32'h8C);
      chk("wr.opd", 32'(b_operand), 32'hFE);
      chk("wr.len2", 32'(b_len2), 32'd1);
      chk("wr.pc", 32'(b_pc), 32'd255);
      chk("wr.addr1", 32'(b_prog_addr), 32'd1);

      // Reset in the middle of an operand fetch
      clear_roms();
      rom_a[0] = 8'h04; rom_a[1] = 8'h84; rom_a[2] = 8'h33;
      do_reset();
      for (int i = 0; i < 10 && a_prog_addr != 8'd2; i++) tick();
      chk("mr.reach", 32'(a_prog_addr), 32'd2);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("mr.valid", 32'(a_valid), 32'd0);
      chk("mr.addr", 32'(a_prog_addr), 32'd0);
      chk("mr.fields", {a_opcode, a_operand, a_pc, 7'd0, a_len2}, 32'd0);
      tick();
      expect_a("mr.e0", 8'h04, 8'h00, 1'b0, 8'd0);
      chk("mr.addr1", 32'(a_prog_addr), 32'd1);

      // run=0 freezes fetch but the queue still drains
      clear_roms();
      rom_a[0] = 8'h08;
      instr_ready = 1'b0;
      do_reset();
      tick();
      expect_a("rn.e0", 8'h08, 8'h00, 1'b0, 8'd0);
      run = 1'b0; instr_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rn.nv", 32'(a_valid), 32'd0);
         chk("rn.addr", 32'(a_prog_addr), 32'd1);
      end
      run = 1'b1;
      tick();
      expect_a("rn.e1", 8'h00, 8'h00, 1'b0, 8'd1);
      chk("rn.addr2", 32'(a_prog_addr), 32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
